// File: rtl/prog_mem_pkg.sv
// Shared CPU definitions: opcode encoding, program-memory FSM states and the NOP word.
package prog_mem_pkg;

  typedef enum logic [3:0] {
    opADD  = 4'h0,
    opADDI = 4'h1,
    opSUB  = 4'h2,
    opSUBI = 4'h3,
    opAND  = 4'h4,
    opOR   = 4'h5,
    opXOR  = 4'h6,
    opLD   = 4'h7,
    opST   = 4'h8,
    opB    = 4'h9,
    opBZ   = 4'hA,
    opBNZ  = 4'hB
  } instrOpcode;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD
  } progMemState_t;

  // ADD X7, X7, X7 has no architectural effect, so it serves as the NOP.
  localparam logic [15:0] INSTR_NOP = {opADD, 3'b0, 3'd7, 3'd7, 3'd7};

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Instruction memory with registered fetch and a streaming program-load port
// that pads every location past the loaded program with NOP.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          fetch_addr,
  input  logic                       fetch_en,
  output logic [INSTR_W-1:0]         instr,
  output logic                       instr_valid,
  input  logic                       load_start,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [INSTR_W-1:0]         load_data,
  input  logic                       load_last,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] load_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(INSTR_NOP);

  progMemState_t state;
  logic [CW-1:0]      ptr;
  logic               fetch_q;
  logic               oor_q;
  logic [INSTR_W-1:0] hold_q;
  logic               valid_q;

  logic [AW-1:0]      fetch_idx;
  logic               oor;
  logic               accept;
  logic               pad_write;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  assign fetch_idx = fetch_addr[AW:1];
  assign oor       = (fetch_addr >> (AW + 1)) != '0;
  assign accept    = (state == LOAD) && load_valid && load_ready;
  assign pad_write = (state == PAD) && (ptr != CW'(DEPTH));

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = fetch_idx;
    mem_wdata = load_data;
    if (accept) begin
      mem_we   = 1'b1;
      mem_addr = ptr[AW-1:0];
    end else if (pad_write) begin
      mem_we    = 1'b1;
      mem_addr  = ptr[AW-1:0];
      mem_wdata = NOP_W;
    end
  end

  mem_array #(
    .DEPTH(DEPTH),
    .WIDTH(INSTR_W),
    .AW(AW)
  ) u_mem (
    .clk(clk),
    .we(mem_we),
    .addr(mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // RAM read data is only meaningful the cycle after a fetch; otherwise the
  // last presented word is replayed from hold_q so stalls keep instr stable.
  always_comb begin
    if (busy) begin
      instr       = NOP_W;
      instr_valid = 1'b0;
    end else if (fetch_q) begin
      instr       = oor_q ? NOP_W : mem_rdata;
      instr_valid = 1'b1;
    end else begin
      instr       = hold_q;
      instr_valid = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      load_count <= '0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      fetch_q    <= 1'b0;
      oor_q      <= 1'b0;
      hold_q     <= NOP_W;
      valid_q    <= 1'b0;
    end else begin
      hold_q  <= instr;
      valid_q <= instr_valid;
      fetch_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_count <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end else if (fetch_en) begin
            fetch_q <= 1'b1;
            oor_q   <= oor;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr        <= ptr + CW'(1);
            load_count <= load_count + CW'(1);
            if (load_last || (ptr == CW'(DEPTH - 1))) begin
              state      <= PAD;
              load_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          if (ptr == CW'(DEPTH)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + CW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset, short load, fetch edges, stall, full load, reset mid-load.
module tb_prog_mem;

  localparam logic [15:0] NOP = 16'h01FF;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_addr;
  logic        fetch_en;
  logic [15:0] instr;
  logic        instr_valid;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic        busy;
  logic [6:0]  load_count;

  int checks = 0;
  int errors = 0;
  int busy_cycles;
  int guard;
  int idx;
  logic ready_seen;
  logic [15:0] prog [5];
  logic [15:0] full [64];

  prog_mem #(.ADDR_W(16), .INSTR_W(16), .DEPTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_addr(fetch_addr),
    .fetch_en(fetch_en),
    .instr(instr),
    .instr_valid(instr_valid),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .load_last(load_last),
    .busy(busy),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    step();
  endtask

  initial begin
    // ADDI X0,X7,3; ADDI X1,X7,2; SUBI X2,X0,1; ADD X0,X1,X2; B -4
    prog[0] = 16'h11C3;
    prog[1] = 16'h13C2;
    prog[2] = 16'h3401;
    prog[3] = 16'h000A;
    prog[4] = 16'h9FFC;
    for (int k = 0; k < 64; k++) full[k] = 16'($urandom);

    reset = 1'b1; fetch_addr = '0; fetch_en = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    step(); step();
    chk("rst_instr", 32'(instr), 32'(NOP));
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_count", 32'(load_count), 0);
    reset = 1'b0;
    step();

    // Short load of 5 words, back to back
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("short_busy_rise", 32'(busy), 1);
    chk("short_ready", 32'(load_ready), 1);
    busy_cycles = busy ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b1; load_data = prog[k]; load_last = (k == 4);
      step();
      if (busy) busy_cycles++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("short_ready_drop", 32'(load_ready), 0);
    guard = 0;
    while (busy && guard < 300) begin
      step();
      if (busy) busy_cycles++;
      guard++;
    end
    chk("short_busy_bound", 32'(guard < 300), 1);
    chk("short_busy_len", 32'(busy_cycles), 65);
    chk("short_count", 32'(load_count), 5);

    fetch(16'd0);  chk("fetch_a0", 32'(instr), 32'(prog[0]));
    chk("fetch_a0_valid", 32'(instr_valid), 1);
    fetch(16'd2);  chk("fetch_a2", 32'(instr), 32'(prog[1]));
    fetch(16'd8);  chk("fetch_a8", 32'(instr), 32'(prog[4]));
    fetch(16'd10); chk("fetch_a10_pad", 32'(instr), 32'(NOP));
    fetch(16'd3);  chk("fetch_a3_odd", 32'(instr), 32'(prog[1]));
    fetch(16'd200); chk("fetch_a200", 32'(instr), 32'(NOP));
    chk("fetch_a200_valid", 32'(instr_valid), 1);

    // Stall: address moves while fetch_en is low
    fetch(16'd2);
    fetch_en = 1'b0;
    fetch_addr = 16'd4; step(); chk("stall_1", 32'(instr), 32'(prog[1]));
    fetch_addr = 16'd6; step(); chk("stall_2", 32'(instr), 32'(prog[3]) ^ 32'(prog[3]) ^ 32'(prog[1]));
    fetch_addr = 16'd8; step(); chk("stall_3", 32'(instr), 32'(prog[1]));
    chk("stall_valid", 32'(instr_valid), 1);
    fetch(16'd4); chk("stall_resume", 32'(instr), 32'(prog[2]));

    // Full load with random gaps; load_last only in gap cycles; stray load_start mid-load
    fetch_en = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    fetch_en = 1'b1; fetch_addr = 16'd0;
    step();
    chk("busy_instr_nop", 32'(instr), 32'(NOP));
    chk("busy_valid_low", 32'(instr_valid), 0);
    idx = 0; guard = 0;
    while (idx < 64 && guard < 1000) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = full[idx];
      load_last  = !load_valid;
      load_start = (idx == 30);
      ready_seen = load_ready;
      step();
      if (load_valid && ready_seen) idx++;
      guard++;
    end
    load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0; fetch_en = 1'b0;
    chk("full_bound", 32'(guard < 1000), 1);
    chk("full_ready_drop", 32'(load_ready), 0);
    chk("full_count", 32'(load_count), 64);
    chk("full_busy_pad", 32'(busy), 1);
    step();
    chk("full_pad_one_cycle", 32'(busy), 0);
    for (int k = 0; k < 64; k++) begin
      fetch(16'(2 * k));
      chk($sformatf("full_rd_%0d", k), 32'(instr), 32'(full[k]));
    end
    fetch(16'd128); chk("full_a128_oor", 32'(instr), 32'(NOP));
    fetch(16'd127); chk("full_a127", 32'(instr), 32'(full[63]));

    // Reset in the middle of a load
    fetch_en = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1; load_data = 16'hA000 + 16'(k); load_last = 1'b0;
      step();
    end
    load_valid = 1'b0;
    chk("mid_count_pre", 32'(load_count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_count", 32'(load_count), 0);
    chk("mid_ready", 32'(load_ready), 0);
    chk("mid_instr", 32'(instr), 32'(NOP));
    chk("mid_valid", 32'(instr_valid), 0);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'h5A5A; load_last = 1'b0; step();
    load_valid = 1'b1; load_data = 16'hC3C3; load_last = 1'b1; step();
    load_valid = 1'b0; load_last = 1'b0;
    guard = 0;
    while (busy && guard < 300) begin
      step();
      guard++;
    end
    chk("reload_bound", 32'(guard < 300), 1);
    chk("reload_count", 32'(load_count), 2);
    fetch(16'd0);   chk("reload_w0", 32'(instr), 32'h5A5A);
    fetch(16'd2);   chk("reload_w1", 32'(instr), 32'hC3C3);
    fetch(16'd4);   chk("reload_w2_nop", 32'(instr), 32'(NOP));
    fetch(16'd6);   chk("reload_w3_nop", 32'(instr), 32'(NOP));
    fetch(16'd126); chk("reload_w63_nop", 32'(instr), 32'(NOP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
